// File: rtl/reg_file_mp.sv
// Multi-port register file with write-through bypass and per-register busy scoreboard.
// Read ports are per-port instances; write resolution is shared by all of them.

module rf_rd_port #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 5,
    parameter int DEPTH    = 32,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_LEN-1:0]             addr,
    input  logic [DEPTH-1:0][WORD_LEN-1:0]  mem,
    input  logic [DEPTH-1:0]                wr_hit,
    input  logic [DEPTH-1:0][WORD_LEN-1:0]  wr_val,
    input  logic [DEPTH-1:0]                busy,
    output logic [WORD_LEN-1:0]             rd_data,
    output logic                            rd_busy
);
    logic byp_hit;

    assign byp_hit = (BYPASS != 0) && wr_hit[addr];

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (addr != '0) begin
            rd_data = byp_hit ? wr_val[addr] : mem[addr];
            // a bypassed read is already satisfied, so no stall
            rd_busy = busy[addr] && !byp_hit;
        end
    end
endmodule

module reg_file_mp #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD*ADDR_LEN-1:0]    rd_addr,
    output logic [NUM_RD*WORD_LEN-1:0]    rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*ADDR_LEN-1:0]    wr_addr,
    input  logic [NUM_WR*WORD_LEN-1:0]    wr_data,
    input  logic                          issue_en,
    input  logic [ADDR_LEN-1:0]           issue_dest,
    output logic [(1<<ADDR_LEN)-1:0]      busy_vec
);
    localparam int DEPTH = 1 << ADDR_LEN;

    logic [NUM_WR-1:0][ADDR_LEN-1:0] wa;
    logic [NUM_WR-1:0][WORD_LEN-1:0] wd;
    logic [NUM_RD-1:0][ADDR_LEN-1:0] ra;
    logic [NUM_RD-1:0][WORD_LEN-1:0] rd;

    logic [DEPTH-1:0][WORD_LEN-1:0] mem;
    logic [DEPTH-1:0][WORD_LEN-1:0] wr_val;
    logic [DEPTH-1:0]               wr_hit;
    logic [DEPTH-1:0]               busy_q;

    assign wa      = wr_addr;
    assign wd      = wr_data;
    assign ra      = rd_addr;
    assign rd_data = rd;

    // Later ports overwrite earlier ones, so the highest index wins a collision.
    always_comb begin
        wr_hit = '0;
        wr_val = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wa[w] != '0) begin
                wr_hit[wa[w]] = 1'b1;
                wr_val[wa[w]] = wd[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++)
                if (wr_hit[r])
                    mem[r] <= wr_val[r];
        end
    end

    // Issue is newer than any write in flight, so it takes priority over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (issue_en && issue_dest == ADDR_LEN'(r))
                    busy_q[r] <= 1'b1;
                else if (wr_hit[r])
                    busy_q[r] <= 1'b0;
            end
        end
    end

    assign busy_vec = {busy_q[DEPTH-1:1], 1'b0};

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            rf_rd_port #(
                .WORD_LEN (WORD_LEN),
                .ADDR_LEN (ADDR_LEN),
                .DEPTH    (DEPTH),
                .BYPASS   (BYPASS)
            ) u_rd (
                .addr     (ra[i]),
                .mem      (mem),
                .wr_hit   (wr_hit),
                .wr_val   (wr_val),
                .busy     (busy_vec),
                .rd_data  (rd[i]),
                .rd_busy  (rd_busy[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: BYPASS=1 and BYPASS=0 instances share stimulus, checked
// against an array/scoreboard reference model plus directed scenarios.
`timescale 1ns/1ps

module tb_reg_file_mp;
    localparam int W = 32, A = 5, NR = 2, NW = 2, D = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR*A-1:0]   rd_addr;
    logic [NR*W-1:0]   rdat_bp, rdat_nb;
    logic [NR-1:0]     rbusy_bp, rbusy_nb;
    logic [NW-1:0]     wr_en;
    logic [NW*A-1:0]   wr_addr;
    logic [NW*W-1:0]   wr_data;
    logic              issue_en;
    logic [A-1:0]      issue_dest;
    logic [D-1:0]      bvec_bp, bvec_nb;

    int checks = 0, failures = 0;

    logic [W-1:0] m_mem [D];
    bit           m_busy[D];

    reg_file_mp #(.WORD_LEN(W), .ADDR_LEN(A), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdat_bp), .rd_busy(rbusy_bp),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_dest(issue_dest), .busy_vec(bvec_bp));

    reg_file_mp #(.WORD_LEN(W), .ADDR_LEN(A), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdat_nb), .rd_busy(rbusy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_dest(issue_dest), .busy_vec(bvec_nb));

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] rd_bp(int i); return rdat_bp[i*W +: W]; endfunction
    function automatic logic [W-1:0] rd_nb(int i); return rdat_nb[i*W +: W]; endfunction

    task automatic set_rd(int i, int a);
        rd_addr[i*A +: A] = A'(a);
    endtask

    task automatic set_wr(int w, bit en, int a, logic [W-1:0] d);
        wr_en[w]           = en;
        wr_addr[w*A +: A]  = A'(a);
        wr_data[w*W +: W]  = d;
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_dest = '0;
    endtask

    // Clock edge plus reference-model update from the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < D; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
        end else begin
            for (int w = 0; w < NW; w++) begin
                int a;
                a = int'(wr_addr[w*A +: A]);
                if (wr_en[w] && a != 0) begin
                    m_mem[a]  = wr_data[w*W +: W];
                    m_busy[a] = 1'b0;
                end
            end
            if (issue_en && issue_dest != 0) m_busy[issue_dest] = 1'b1;
        end
        #1;
    endtask

    // ---------------- reference model queries ----------------
    function automatic logic [W-1:0] exp_rd(int a, bit byp);
        logic [W-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        if (byp)
            for (int w = 0; w < NW; w++)
                if (wr_en[w] && int'(wr_addr[w*A +: A]) == a) v = wr_data[w*W +: W];
        return v;
    endfunction

    function automatic bit exp_busy(int a, bit byp);
        bit hit = 1'b0;
        if (a == 0) return 1'b0;
        for (int w = 0; w < NW; w++)
            if (wr_en[w] && int'(wr_addr[w*A +: A]) == a) hit = 1'b1;
        return m_busy[a] && !(byp && hit);
    endfunction

    function automatic logic [D-1:0] exp_bvec();
        logic [D-1:0] v = '0;
        for (int r = 1; r < D; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        set_wr(0, 1, 5, 32'hDEAD_BEEF);
        tick();
        idle(); issue_en = 1; issue_dest = 6;
        tick();
        idle(); set_rd(0, 5); set_rd(1, 6);
        #1;
        checks++;
        if (rd_bp(0) !== 32'hDEAD_BEEF || bvec_bp[6] !== 1'b1) begin
            failures++;
            $display("FAIL reset_preload got=%h busy6=%b exp=deadbeef busy6=1", rd_bp(0), bvec_bp[6]);
        end
        rst = 1; set_wr(1, 1, 5, 32'h1234_5678); issue_en = 1; issue_dest = 7;
        tick();
        idle();
        for (int r = 0; r < D; r++) begin
            set_rd(0, r); set_rd(1, D - 1 - r);
            #0.2;
            checks++;
            if (rd_bp(0) !== '0 || rd_bp(1) !== '0 || rd_nb(0) !== '0 || rd_nb(1) !== '0 ||
                rbusy_bp !== '0 || rbusy_nb !== '0) begin
                failures++;
                $display("FAIL reset_clear r=%0d got bp=%h/%h nb=%h/%h busy=%b/%b exp=0",
                         r, rd_bp(0), rd_bp(1), rd_nb(0), rd_nb(1), rbusy_bp, rbusy_nb);
            end
        end
        checks++;
        if (bvec_bp !== '0 || bvec_nb !== '0) begin
            failures++;
            $display("FAIL reset_busy_vec got=%h/%h exp=0", bvec_bp, bvec_nb);
        end
        tick();
    endtask

    task automatic test_r0();
        idle();
        set_wr(0, 1, 0, 32'hFFFF_FFFF); issue_en = 1; issue_dest = 0;
        set_rd(0, 0); set_rd(1, 0);
        #1;
        checks++;
        if (rd_bp(0) !== '0 || rd_nb(1) !== '0 || rbusy_bp !== '0) begin
            failures++;
            $display("FAIL r0_same_cycle got=%h/%h busy=%b exp=0", rd_bp(0), rd_nb(1), rbusy_bp);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_bp(0) !== '0 || rd_nb(0) !== '0 || bvec_bp[0] !== 1'b0 || bvec_nb !== exp_bvec()) begin
            failures++;
            $display("FAIL r0_after got=%h/%h bvec=%h exp=0 bvec=%h", rd_bp(0), rd_nb(0), bvec_nb, exp_bvec());
        end
    endtask

    task automatic test_collision();
        logic [W-1:0] old3;
        idle();
        old3 = m_mem[3];
        set_wr(0, 1, 3, 32'h1111_1111); set_wr(1, 1, 3, 32'h2222_2222);
        set_rd(0, 3);
        #1;
        checks++;
        if (rd_bp(0) !== 32'h2222_2222 || rd_nb(0) !== old3) begin
            failures++;
            $display("FAIL collision_bypass got=%h/%h exp=22222222/%h", rd_bp(0), rd_nb(0), old3);
        end
        tick();
        idle(); set_rd(0, 3); set_rd(1, 3);
        #1;
        checks++;
        if (rd_bp(0) !== 32'h2222_2222 || rd_nb(1) !== 32'h2222_2222) begin
            failures++;
            $display("FAIL collision_stored got=%h/%h exp=22222222", rd_bp(0), rd_nb(1));
        end
    endtask

    task automatic test_bypass();
        idle(); set_wr(1, 1, 7, 32'h0000_0777);
        tick();
        idle();
        set_wr(0, 1, 7, 32'hCAFE_0007); set_rd(0, 7); set_rd(1, 8);
        #1;
        checks++;
        if (rd_bp(0) !== 32'hCAFE_0007) begin
            failures++;
            $display("FAIL bypass_on got=%h exp=cafe0007", rd_bp(0));
        end
        checks++;
        if (rd_nb(0) !== 32'h0000_0777) begin
            failures++;
            $display("FAIL bypass_off got=%h exp=00000777", rd_nb(0));
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_bp(0) !== 32'hCAFE_0007 || rd_nb(0) !== 32'hCAFE_0007) begin
            failures++;
            $display("FAIL bypass_stored got=%h/%h exp=cafe0007", rd_bp(0), rd_nb(0));
        end
    endtask

    task automatic test_scoreboard();
        idle(); issue_en = 1; issue_dest = 9;
        tick();
        idle(); set_rd(0, 9); set_rd(1, 9);
        #1;
        checks++;
        if (rbusy_bp !== 2'b11 || rbusy_nb !== 2'b11 || bvec_bp[9] !== 1'b1) begin
            failures++;
            $display("FAIL sb_busy got=%b/%b v9=%b exp=11/11 v9=1", rbusy_bp, rbusy_nb, bvec_bp[9]);
        end
        tick();
        set_wr(1, 1, 9, 32'h0000_0099);
        #1;
        checks++;
        if (rbusy_bp !== 2'b00 || rbusy_nb !== 2'b11 || rd_bp(1) !== 32'h99) begin
            failures++;
            $display("FAIL sb_wb_cycle got=%b/%b data=%h exp=00/11 data=99", rbusy_bp, rbusy_nb, rd_bp(1));
        end
        tick();
        idle();
        #1;
        checks++;
        if (bvec_bp[9] !== 1'b0 || bvec_nb[9] !== 1'b0 || rd_nb(0) !== 32'h99) begin
            failures++;
            $display("FAIL sb_after got=%b/%b data=%h exp=0/0 data=99", bvec_bp[9], bvec_nb[9], rd_nb(0));
        end
    endtask

    task automatic test_race();
        idle(); issue_en = 1; issue_dest = 4;
        tick();
        idle(); issue_en = 1; issue_dest = 4; set_wr(0, 1, 4, 32'h44);
        tick();
        idle(); set_rd(0, 4); set_rd(1, 4);
        #1;
        checks++;
        if (rd_bp(0) !== 32'h44 || bvec_bp[4] !== 1'b1 || bvec_nb[4] !== 1'b1 || rbusy_bp !== 2'b11) begin
            failures++;
            $display("FAIL race got=%h v4=%b/%b rb=%b exp=44 v4=1/1 rb=11",
                     rd_bp(0), bvec_bp[4], bvec_nb[4], rbusy_bp);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 39) == 0);
            for (int w = 0; w < NW; w++)
                set_wr(w, $urandom_range(0, 2) != 0,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, D - 1) : $urandom_range(0, 7),
                       $urandom);
            issue_en   = $urandom_range(0, 1);
            issue_dest = A'($urandom_range(0, 7));
            for (int i = 0; i < NR; i++)
                set_rd(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, D - 1) : $urandom_range(0, 7));
            #1;
            for (int i = 0; i < NR; i++) begin
                int a;
                a = int'(rd_addr[i*A +: A]);
                checks++;
                if (rd_bp(i) !== exp_rd(a, 1) || rd_nb(i) !== exp_rd(a, 0)) begin
                    failures++;
                    $display("FAIL rand_data n=%0d p=%0d a=%0d got=%h/%h exp=%h/%h",
                             n, i, a, rd_bp(i), rd_nb(i), exp_rd(a, 1), exp_rd(a, 0));
                end
                checks++;
                if (rbusy_bp[i] !== exp_busy(a, 1) || rbusy_nb[i] !== exp_busy(a, 0)) begin
                    failures++;
                    $display("FAIL rand_busy n=%0d p=%0d a=%0d got=%b/%b exp=%b/%b",
                             n, i, a, rbusy_bp[i], rbusy_nb[i], exp_busy(a, 1), exp_busy(a, 0));
                end
            end
            checks++;
            if (bvec_bp !== exp_bvec() || bvec_nb !== exp_bvec()) begin
                failures++;
                $display("FAIL rand_bvec n=%0d got=%h/%h exp=%h", n, bvec_bp, bvec_nb, exp_bvec());
            end
            tick();
        end
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rst = 1'b1;
        tick();
        test_reset();
        test_r0();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_race();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
